sram_master: RTL and testbench
==============================

# sram_master

Initiator for the 4x4 single-port SRAM. It accepts single read/write requests on a valid/ready interface and drives the SRAM's en/wr/addr/data pins with the exact two-cycle read sequence the array requires. It returns read data on a one-cycle response strobe. A built-in self-test (BIST) writes a seeded pattern to every address, reads it back and counts mismatches. It sits between the UVM-driven request agent, or a system bus, and the SRAM instance.

## Interface
- ADDR_W, 2, SRAM address width; depth = 2**ADDR_W
- DATA_W, 4, SRAM data width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  master can accept a request
- req_wr  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  one-cycle strobe: rsp_rdata valid
- rsp_rdata  output  DATA_W  read data; holds until next read response
- bist_start  input  1  start self-test; sampled only in IDLE
- bist_seed  input  DATA_W  pattern seed; sampled with bist_start
- bist_busy  output  1  self-test in progress
- bist_done  output  1  one-cycle strobe at self-test end
- bist_pass  output  1  1 if last self-test had 0 mismatches
- bist_err_cnt  output  ADDR_W+1  mismatch count of last self-test
- mem_en  output  1  to SRAM en
- mem_wr  output  1  to SRAM wr
- mem_addr  output  ADDR_W  to SRAM addr
- mem_wdata  output  DATA_W  to SRAM data_in
- mem_rdata  input  DATA_W  from SRAM data_out; Z unless en && !wr

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_SAMPLE, B_WR, B_RD_ISSUE, B_RD_SAMPLE.
- req_ready = (state == IDLE) && !bist_start. Handshake occurs on req_valid && req_ready at a rising edge. Request fields are latched at that edge.
- bist_start in IDLE takes priority over req_valid. The request is not accepted that cycle.
- WRITE: mem_en=1, mem_wr=1, mem_addr/mem_wdata = latched values. Next state is IDLE. No response strobe is generated for writes.
- RD_ISSUE: mem_en=1, mem_wr=0, mem_addr = latched address. The SRAM captures its internal read register at the end of this cycle.
- RD_SAMPLE: same pin values as RD_ISSUE. mem_rdata is valid during this cycle and is registered into rsp_rdata at its closing edge. rsp_valid=1 in the following cycle. Next state is IDLE.
- BIST: latch the seed, clear the error counter, set i=0.
  - B_WR runs for i = 0..2**ADDR_W-1, one address per cycle: mem_en=1, mem_wr=1, mem_addr=i, mem_wdata = seed + i (mod 2**DATA_W).
  - Then, for each i, B_RD_ISSUE followed by B_RD_SAMPLE. In B_RD_SAMPLE, compare mem_rdata against seed + i. On a mismatch or any X/Z, increment bist_err_cnt.
  - After the last sample, go to IDLE with bist_done=1 for one cycle and bist_pass = (bist_err_cnt == 0).
  - bist_err_cnt and bist_pass hold until the next bist_start.
- Outside active states: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0. The SRAM bus is then Z.
- mem_rdata is sampled only in RD_SAMPLE and B_RD_SAMPLE.
- The address counter wraps modulo 2**ADDR_W. The BIST loop terminates on i == 2**ADDR_W-1, not on wrap.

## Timing
- Reset (rst=0 at an edge): state=IDLE. The following outputs are 0: rsp_valid, rsp_rdata, bist_busy, bist_done, bist_pass, bist_err_cnt, mem_en, mem_wr, mem_addr, mem_wdata. req_ready is 0 while rst=0 and 1 in the first cycle with rst=1.
- Reset mid-operation aborts immediately. No rsp_valid or bist_done follows, and BIST results are cleared.
- Write: accepted at edge E, pins active in cycle E+1, req_ready=1 again in E+2. Throughput is 1 write per 2 cycles.
- Read: accepted at edge E. RD_ISSUE runs in E+1 and RD_SAMPLE in E+2. rsp_valid and req_ready are both 1 in E+3. Latency is 3 cycles; throughput is 1 read per 3 cycles.
- A new request may be accepted in the same cycle rsp_valid is high.
- BIST with DEPTH=4: start at edge E, bist_busy=1 from E+1. B_WR runs in E+1..E+4 and reads run in E+5..E+12. bist_done=1 and bist_busy=0 in E+13.

## Test plan
- Reset, then write addr 2 = 4'hA, then read addr 2. Required: rsp_valid exactly 3 cycles after the read handshake with rsp_rdata=4'hA; mem_en high for exactly 2 cycles with mem_wr=0.
- Back-to-back: req_valid held high with writes to all 4 addresses (data 1,2,3,4), then 4 reads. Required: req_ready toggles per the timing rules and responses return 1,2,3,4 in order.
- Read after reset with no write. Required: rsp_rdata=0, since the SRAM clears on reset.
- BIST with seed 4'hE. Required: writes E,F,0,1 to addresses 0..3; bist_done at E+13; bist_pass=1; bist_err_cnt=0.
- BIST with an error injected: force mem_rdata=4'h0 during the address-1 sample. Required: bist_err_cnt=1 and bist_pass=0.
- bist_start and req_valid asserted in the same cycle: BIST runs and the request is accepted only after bist_done. Separately, assert rst=0 during RD_ISSUE: no rsp_valid follows and all outputs return to their reset values.

Source files
------------

// File: rtl/sram_master.sv
// ---------------------------------------------------------------------------
// sram_master
//
// Initiator for the small single-port SRAM array. It accepts single read or
// write requests on a valid/ready interface and turns each one into the pin
// sequence the array needs:
//   - a write is one cycle with en=1, wr=1
//   - a read is two cycles with en=1, wr=0 (issue, then sample)
// Read data comes back on a one-cycle response strobe.
//
// A built-in self-test (BIST) writes seed+i to every address i, reads every
// address back and counts the words that differ from seed+i.
//
// Ports
//   clk, rst        clock (rising edge); synchronous active-low reset
//   req_valid       request present
//   req_ready       master can take a request this cycle
//   req_wr          1 = write, 0 = read
//   req_addr        request address
//   req_wdata       write data
//   rsp_valid       one-cycle strobe, rsp_rdata carries read data
//   rsp_rdata       last read data, held until the next read response
//   bist_start      start self-test (only looked at while idle)
//   bist_seed       pattern seed, captured with bist_start
//   bist_busy       self-test in progress
//   bist_done       one-cycle strobe when the self-test finishes
//   bist_pass       last self-test saw no mismatches
//   bist_err_cnt    mismatch count of the last self-test
//   mem_en/mem_wr   SRAM enable / write strobe
//   mem_addr        SRAM address
//   mem_wdata       SRAM write data
//   mem_rdata       SRAM read data (only meaningful while en && !wr)
// ---------------------------------------------------------------------------
module sram_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,

  input  logic              bist_start,
  input  logic [DATA_W-1:0] bist_seed,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [ADDR_W:0]   bist_err_cnt,

  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_SAMPLE,
    B_WR,
    B_RD_ISSUE,
    B_RD_SAMPLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] idx;

  logic [ADDR_W-1:0] idx_inc;
  logic              idx_last;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] next_wdata;
  logic              bist_mismatch;
  logic [CNT_W-1:0]  err_cnt_next;

  // The ready term looks at bist_start directly so a self-test request wins
  // over a bus request arriving in the same idle cycle, and stays low while
  // reset is held.
  assign req_ready = rst && (state == IDLE) && !bist_start;

  // BIST address walk and the pattern values derived from it. The walk ends
  // on the last address rather than on the wrap back to zero.
  always_comb begin
    idx_inc    = idx + ADDR_W'(1);
    idx_last   = (idx == {ADDR_W{1'b1}});
    exp_data   = seed + DATA_W'(idx);
    next_wdata = seed + DATA_W'(idx_inc);
  end

  // Case inequality so an undriven or unknown read bus also counts as an
  // error instead of silently matching.
  always_comb begin
    bist_mismatch = (mem_rdata !== exp_data);
    err_cnt_next  = bist_err_cnt + CNT_W'(bist_mismatch);
  end

  // Single control FSM. All SRAM pins and status outputs are registered: the
  // value loaded at an edge is the value for the state entered at that edge,
  // so every branch that moves into an active state also loads the pins that
  // state drives. Pins default back to zero, which parks the SRAM bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      lat_addr     <= '0;
      seed         <= '0;
      idx          <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      bist_busy    <= 1'b0;
      bist_done    <= 1'b0;
      bist_pass    <= 1'b0;
      bist_err_cnt <= '0;
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      bist_done <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;

      case (state)
        IDLE: begin
          if (bist_start) begin
            seed         <= bist_seed;
            idx          <= '0;
            bist_err_cnt <= '0;
            bist_pass    <= 1'b0;
            bist_busy    <= 1'b1;
            state        <= B_WR;
            mem_en       <= 1'b1;
            mem_wr       <= 1'b1;
            mem_addr     <= '0;
            mem_wdata    <= bist_seed;
          end else if (req_valid) begin
            lat_addr <= req_addr;
            mem_en   <= 1'b1;
            mem_addr <= req_addr;
            if (req_wr) begin
              state     <= WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end

        WRITE: begin
          state <= IDLE;
        end

        // The array latches its read register at the end of the issue cycle,
        // so the address must stay put for the sample cycle as well.
        RD_ISSUE: begin
          state    <= RD_SAMPLE;
          mem_en   <= 1'b1;
          mem_addr <= lat_addr;
        end

        RD_SAMPLE: begin
          rsp_rdata <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end

        B_WR: begin
          if (idx_last) begin
            idx      <= '0;
            state    <= B_RD_ISSUE;
            mem_en   <= 1'b1;
            mem_addr <= '0;
          end else begin
            idx       <= idx_inc;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b1;
            mem_addr  <= idx_inc;
            mem_wdata <= next_wdata;
          end
        end

        B_RD_ISSUE: begin
          state    <= B_RD_SAMPLE;
          mem_en   <= 1'b1;
          mem_addr <= idx;
        end

        // Pass/fail uses the count including this last sample.
        B_RD_SAMPLE: begin
          bist_err_cnt <= err_cnt_next;
          if (idx_last) begin
            idx       <= '0;
            state     <= IDLE;
            bist_busy <= 1'b0;
            bist_done <= 1'b1;
            bist_pass <= (err_cnt_next == '0);
          end else begin
            idx      <= idx_inc;
            state    <= B_RD_ISSUE;
            mem_en   <= 1'b1;
            mem_addr <= idx_inc;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// ---------------------------------------------------------------------------
// tb_sram_master
//
// Directed bench for sram_master. A behavioural 4x4 SRAM sits on the mem_*
// pins: writes land at the clock edge, reads load an internal read register
// at the edge and that register drives the bus only while en && !wr, so data
// is visible in the second read cycle only. The array clears on reset.
// Inputs change just after the falling edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_sram_master;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              bist_start;
  logic [DATA_W-1:0] bist_seed;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_pass;
  logic [ADDR_W:0]   bist_err_cnt;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              inject_zero;
  logic [DATA_W-1:0] sram_array [4];
  logic [DATA_W-1:0] sram_rd;
  wire  [DATA_W-1:0] sram_out;

  int errors;
  int checks;

  sram_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .bist_start   (bist_start),
    .bist_seed    (bist_seed),
    .bist_busy    (bist_busy),
    .bist_done    (bist_done),
    .bist_pass    (bist_pass),
    .bist_err_cnt (bist_err_cnt),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with a registered read path and reset clear.
  always @(posedge clk) begin
    if (!rst) begin
      for (int a = 0; a < 4; a++) sram_array[a] <= '0;
      sram_rd <= '0;
    end else if (mem_en) begin
      if (mem_wr) sram_array[mem_addr] <= mem_wdata;
      else        sram_rd <= sram_array[mem_addr];
    end
  end

  assign sram_out  = (mem_en && !mem_wr) ? sram_rd : 'z;
  assign mem_rdata = inject_zero ? 4'h0 : sram_out;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic wr,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata,
                               input logic start,
                               input logic [DATA_W-1:0] seed);
    req_valid  = valid;
    req_wr     = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    bist_start = start;
    bist_seed  = seed;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Every output at its reset value, with reset still asserted.
  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_req_ready"},    32'(req_ready),    32'h0);
    checkOutput({tag, "_rsp_valid"},    32'(rsp_valid),    32'h0);
    checkOutput({tag, "_rsp_rdata"},    32'(rsp_rdata),    32'h0);
    checkOutput({tag, "_bist_busy"},    32'(bist_busy),    32'h0);
    checkOutput({tag, "_bist_done"},    32'(bist_done),    32'h0);
    checkOutput({tag, "_bist_pass"},    32'(bist_pass),    32'h0);
    checkOutput({tag, "_bist_err_cnt"}, 32'(bist_err_cnt), 32'h0);
    checkOutput({tag, "_mem_en"},       32'(mem_en),       32'h0);
    checkOutput({tag, "_mem_wr"},       32'(mem_wr),       32'h0);
    checkOutput({tag, "_mem_addr"},     32'(mem_addr),     32'h0);
    checkOutput({tag, "_mem_wdata"},    32'(mem_wdata),    32'h0);
  endtask

  // Walks self-test cycles 1..12 after the start edge (caller is already in
  // cycle 1) and returns in cycle 13. Cycles 1-4 write seed+i to address i,
  // cycles 5-12 alternate issue/sample for addresses 0..3. inject_cycle
  // selects a cycle whose read bus is forced to zero (0 = none).
  task automatic bist_walk(input string tag, input logic [DATA_W-1:0] seed,
                           input int inject_cycle);
    logic [DATA_W-1:0] pattern;
    for (int k = 1; k <= 12; k++) begin
      inject_zero = (k == inject_cycle);
      checkOutput($sformatf("%s_busy_c%0d", tag, k), 32'(bist_busy), 32'h1);
      checkOutput($sformatf("%s_en_c%0d", tag, k), 32'(mem_en), 32'h1);
      checkOutput($sformatf("%s_ready_c%0d", tag, k), 32'(req_ready), 32'h0);
      checkOutput($sformatf("%s_done_c%0d", tag, k), 32'(bist_done), 32'h0);
      if (k <= 4) begin
        pattern = seed + DATA_W'(k - 1);
        checkOutput($sformatf("%s_wr_c%0d", tag, k), 32'(mem_wr), 32'h1);
        checkOutput($sformatf("%s_addr_c%0d", tag, k), 32'(mem_addr), 32'(k - 1));
        checkOutput($sformatf("%s_wdata_c%0d", tag, k), 32'(mem_wdata), 32'(pattern));
      end else begin
        checkOutput($sformatf("%s_wr_c%0d", tag, k), 32'(mem_wr), 32'h0);
        checkOutput($sformatf("%s_addr_c%0d", tag, k), 32'(mem_addr), 32'((k - 5) / 2));
      end
      step();
    end
    inject_zero = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    inject_zero = 1'b0;
    rst         = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);

    // Reset values, then release.
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b1;
    #1;
    checkOutput("reset_release_ready", 32'(req_ready), 32'h1);

    // Write 4'hA to address 2: pins active for one cycle, ready two later.
    $display("[TB] single write then read");
    applyStimulus(1'b1, 1'b1, 2'd2, 4'hA, 1'b0, '0);
    checkOutput("wr_ready_at_hs", 32'(req_ready), 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("wr_en",    32'(mem_en),    32'h1);
    checkOutput("wr_wr",    32'(mem_wr),    32'h1);
    checkOutput("wr_addr",  32'(mem_addr),  32'h2);
    checkOutput("wr_wdata", 32'(mem_wdata), 32'hA);
    checkOutput("wr_busy_ready", 32'(req_ready), 32'h0);
    step();
    checkOutput("wr_done_en",    32'(mem_en),    32'h0);
    checkOutput("wr_done_wdata", 32'(mem_wdata), 32'h0);
    checkOutput("wr_done_ready", 32'(req_ready), 32'h1);
    checkOutput("wr_no_rsp",     32'(rsp_valid), 32'h0);

    // Read address 2: two enable cycles, response in the third.
    applyStimulus(1'b1, 1'b0, 2'd2, '0, 1'b0, '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("rd_issue_en",    32'(mem_en),    32'h1);
    checkOutput("rd_issue_wr",    32'(mem_wr),    32'h0);
    checkOutput("rd_issue_addr",  32'(mem_addr),  32'h2);
    checkOutput("rd_issue_rsp",   32'(rsp_valid), 32'h0);
    checkOutput("rd_issue_ready", 32'(req_ready), 32'h0);
    step();
    checkOutput("rd_sample_en",   32'(mem_en),    32'h1);
    checkOutput("rd_sample_wr",   32'(mem_wr),    32'h0);
    checkOutput("rd_sample_addr", 32'(mem_addr),  32'h2);
    checkOutput("rd_sample_rsp",  32'(rsp_valid), 32'h0);
    step();
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rd_rsp_rdata", 32'(rsp_rdata), 32'hA);
    checkOutput("rd_rsp_en",    32'(mem_en),    32'h0);
    checkOutput("rd_rsp_ready", 32'(req_ready), 32'h1);
    step();
    checkOutput("rd_strobe_end", 32'(rsp_valid), 32'h0);
    checkOutput("rd_rdata_hold", 32'(rsp_rdata), 32'hA);

    // Back-to-back with req_valid held: writes 1..4, then reads 0..3.
    $display("[TB] back-to-back traffic");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, ADDR_W'(i), DATA_W'(i + 1), 1'b0, '0);
      checkOutput($sformatf("b2b_wr%0d_ready", i), 32'(req_ready), 32'h1);
      step();
      checkOutput($sformatf("b2b_wr%0d_busy", i),  32'(req_ready), 32'h0);
      checkOutput($sformatf("b2b_wr%0d_addr", i),  32'(mem_addr),  32'(i));
      checkOutput($sformatf("b2b_wr%0d_wdata", i), 32'(mem_wdata), 32'(i + 1));
      step();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, ADDR_W'(i), '0, 1'b0, '0);
      checkOutput($sformatf("b2b_rd%0d_ready", i), 32'(req_ready), 32'h1);
      step();
      checkOutput($sformatf("b2b_rd%0d_busy1", i), 32'(req_ready), 32'h0);
      step();
      checkOutput($sformatf("b2b_rd%0d_busy2", i), 32'(req_ready), 32'h0);
      step();
      checkOutput($sformatf("b2b_rd%0d_valid", i), 32'(rsp_valid), 32'h1);
      checkOutput($sformatf("b2b_rd%0d_rdata", i), 32'(rsp_rdata), 32'(i + 1));
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);

    // Read after reset returns the cleared array contents.
    $display("[TB] read after reset");
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd3, '0, 1'b0, '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) step();
    checkOutput("rar_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rar_rdata", 32'(rsp_rdata), 32'h0);
    step();

    // Self-test with seed E: pattern E,F,0,1, clean pass.
    $display("[TB] self-test seed E");
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'hE);
    checkOutput("bist_start_ready", 32'(req_ready), 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    bist_walk("bistE", 4'hE, 0);
    checkOutput("bistE_done",  32'(bist_done),    32'h1);
    checkOutput("bistE_busy",  32'(bist_busy),    32'h0);
    checkOutput("bistE_pass",  32'(bist_pass),    32'h1);
    checkOutput("bistE_errs",  32'(bist_err_cnt), 32'h0);
    checkOutput("bistE_en",    32'(mem_en),       32'h0);
    step();
    checkOutput("bistE_done_end",  32'(bist_done), 32'h0);
    checkOutput("bistE_pass_hold", 32'(bist_pass), 32'h1);

    // Self-test with the address-1 sample (cycle 8) forced to zero.
    $display("[TB] self-test with injected error");
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 4'hE);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("bistX_pass_cleared", 32'(bist_pass), 32'h0);
    bist_walk("bistX", 4'hE, 8);
    checkOutput("bistX_done", 32'(bist_done),    32'h1);
    checkOutput("bistX_errs", 32'(bist_err_cnt), 32'h1);
    checkOutput("bistX_pass", 32'(bist_pass),    32'h0);
    repeat (3) step();
    checkOutput("bistX_errs_hold", 32'(bist_err_cnt), 32'h1);

    // bist_start and a read of address 2 together: self-test first, then
    // the held request goes through and sees seed+2 = 7.
    $display("[TB] self-test versus pending request");
    applyStimulus(1'b1, 1'b0, 2'd2, '0, 1'b1, 4'h5);
    checkOutput("prio_ready", 32'(req_ready), 32'h0);
    step();
    applyStimulus(1'b1, 1'b0, 2'd2, '0, 1'b0, '0);
    bist_walk("bist5", 4'h5, 0);
    checkOutput("prio_done",  32'(bist_done), 32'h1);
    checkOutput("prio_pass",  32'(bist_pass), 32'h1);
    checkOutput("prio_ready_after", 32'(req_ready), 32'h1);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("prio_rd_en",   32'(mem_en),   32'h1);
    checkOutput("prio_rd_wr",   32'(mem_wr),   32'h0);
    checkOutput("prio_rd_addr", 32'(mem_addr), 32'h2);
    repeat (2) step();
    checkOutput("prio_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("prio_rsp_rdata", 32'(rsp_rdata), 32'h7);
    step();

    // Reset asserted during RD_ISSUE aborts the read and clears results.
    $display("[TB] reset during read");
    applyStimulus(1'b1, 1'b0, 2'd1, '0, 1'b0, '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("abort_issue_en", 32'(mem_en), 32'h1);
    rst = 1'b0;
    step();
    check_reset_outputs("abort");
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput($sformatf("abort_no_rsp%0d", k),  32'(rsp_valid), 32'h0);
      checkOutput($sformatf("abort_no_done%0d", k), 32'(bist_done), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
